// File: rtl/proc_bus_pkg.sv
// Shared types and constants for the two-master processor register-port arbiter.
// Holds the FSM encoding, master ids and the default timeout read data.
package proc_bus_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_GRANT0 = 2'd1,
    ARB_GRANT1 = 2'd2
  } arb_state_e;

  localparam logic        MASTER0           = 1'b0;
  localparam logic        MASTER1           = 1'b1;
  localparam logic [31:0] DEFAULT_ERR_RDATA = 32'hDEAD_BEEF;

  function automatic logic other_master(input logic id);
    return ~id;
  endfunction

endpackage

// File: rtl/proc_bus_watchdog.sv
// Stall watchdog: saturating wait counter, expiry compare and registered timeout report.
// expire_o is combinational so the arbiter can terminate the transaction in the same cycle.
module proc_bus_watchdog
  import proc_bus_pkg::*;
#(
  parameter int TIMEOUT = 64
) (
  input  logic clk,
  input  logic reset,
  input  logic clr_i,
  input  logic stall_i,
  input  logic master_i,
  output logic expire_o,
  output logic timeout_pulse_o,
  output logic timeout_master_o
);

  localparam int              CNT_W = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pulse_q, pulse_d;
  logic             master_q, master_d;

  assign expire_o = stall_i && (cnt_q == LIMIT);

  always_comb begin
    cnt_d    = cnt_q;
    pulse_d  = expire_o;
    master_d = expire_o ? master_i : master_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (stall_i && (cnt_q != LIMIT)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q    <= '0;
      pulse_q  <= 1'b0;
      master_q <= MASTER0;
    end else begin
      cnt_q    <= cnt_d;
      pulse_q  <= pulse_d;
      master_q <= master_d;
    end
  end

  assign timeout_pulse_o  = pulse_q;
  assign timeout_master_o = master_q;

endmodule

// File: rtl/proc_bus_arbiter.sv
// Two-master round-robin arbiter for the processor's valid/ready register port.
// The grant is held for a whole transaction; a watchdog ends stalled ones with an error word.
module proc_bus_arbiter
  import proc_bus_pkg::*;
#(
  parameter int                 ADDR_W    = 5,
  parameter int                 DATA_W    = 32,
  parameter int                 TIMEOUT   = 64,
  parameter logic [DATA_W-1:0]  ERR_RDATA = DATA_W'(DEFAULT_ERR_RDATA)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                m0_valid,
  output logic                m0_ready,
  input  logic [ADDR_W-1:0]   m0_addr,
  input  logic [DATA_W-1:0]   m0_wdata,
  input  logic [DATA_W/8-1:0] m0_wstrb,
  output logic [DATA_W-1:0]   m0_rdata,
  input  logic                m1_valid,
  output logic                m1_ready,
  input  logic [ADDR_W-1:0]   m1_addr,
  input  logic [DATA_W-1:0]   m1_wdata,
  input  logic [DATA_W/8-1:0] m1_wstrb,
  output logic [DATA_W-1:0]   m1_rdata,
  output logic                s_valid,
  input  logic                s_ready,
  output logic [ADDR_W-1:0]   s_addr,
  output logic [DATA_W-1:0]   s_wdata,
  output logic [DATA_W/8-1:0] s_wstrb,
  input  logic [DATA_W-1:0]   s_rdata,
  output logic                timeout_pulse,
  output logic                timeout_master,
  output logic                grant_id,
  output logic                busy
);

  arb_state_e          state_q, state_d;
  logic                prio_q, prio_d;
  logic                granted;
  logic                cur_id;
  logic                sel_valid;
  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_W-1:0]   sel_wdata;
  logic [DATA_W/8-1:0] sel_wstrb;
  logic                wd_stall;
  logic                wd_expire;
  logic                done;
  logic [DATA_W-1:0]   rsp_data;

  assign granted   = (state_q != ARB_IDLE);
  assign cur_id    = (state_q == ARB_GRANT1) ? MASTER1 : MASTER0;
  assign sel_valid = (cur_id == MASTER1) ? m1_valid : m0_valid;
  assign sel_addr  = (cur_id == MASTER1) ? m1_addr  : m0_addr;
  assign sel_wdata = (cur_id == MASTER1) ? m1_wdata : m0_wdata;
  assign sel_wstrb = (cur_id == MASTER1) ? m1_wstrb : m0_wstrb;

  // Only a live, unanswered request counts as a stall; a withdrawn request just drops the grant.
  assign wd_stall = granted && sel_valid && !s_ready;

  proc_bus_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk              (clk),
    .reset            (reset),
    .clr_i            (!granted),
    .stall_i          (wd_stall),
    .master_i         (cur_id),
    .expire_o         (wd_expire),
    .timeout_pulse_o  (timeout_pulse),
    .timeout_master_o (timeout_master)
  );

  assign done     = granted && (s_ready || wd_expire);
  assign rsp_data = wd_expire ? ERR_RDATA : s_rdata;
  assign busy     = granted;
  assign grant_id = cur_id;

  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    state_d  = state_q;
    prio_d   = prio_q;
    s_valid  = 1'b0;
    s_addr   = '0;
    s_wdata  = '0;
    s_wstrb  = '0;
    m0_ready = 1'b0;
    m1_ready = 1'b0;
    m0_rdata = '0;
    m1_rdata = '0;

    unique case (state_q)
      ARB_IDLE: begin
        if (m0_valid && m1_valid) begin
          state_d = (prio_q == MASTER1) ? ARB_GRANT1 : ARB_GRANT0;
        end else if (m0_valid) begin
          state_d = ARB_GRANT0;
        end else if (m1_valid) begin
          state_d = ARB_GRANT1;
        end
      end
      ARB_GRANT0, ARB_GRANT1: begin
        s_valid = sel_valid && !wd_expire;
        s_addr  = sel_addr;
        s_wdata = sel_wdata;
        s_wstrb = sel_wstrb;
        if (cur_id == MASTER1) begin
          m1_ready = done;
          m1_rdata = rsp_data;
        end else begin
          m0_ready = done;
          m0_rdata = rsp_data;
        end
        // Completion hands priority to the other master; a withdrawal leaves it untouched.
        if (done) begin
          state_d = ARB_IDLE;
          prio_d  = other_master(cur_id);
        end else if (!sel_valid) begin
          state_d = ARB_IDLE;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ARB_IDLE;
      prio_q  <= MASTER0;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
    end
  end

endmodule

// File: tb/tb_proc_bus_arbiter.sv
// Scoreboard bench for proc_bus_arbiter: drivers push expected responses, a monitor retires them.
// A latency-programmable slave model answers on the shared port.
module tb_proc_bus_arbiter;
  import proc_bus_pkg::*;

  localparam int AW = 5;
  localparam int DW = 32;
  localparam int SW = DW / 8;
  localparam int TO = 8;

  logic          clk;
  logic          reset;
  logic          m0_valid, m0_ready, m1_valid, m1_ready;
  logic [AW-1:0] m0_addr, m1_addr, s_addr;
  logic [DW-1:0] m0_wdata, m1_wdata, s_wdata;
  logic [SW-1:0] m0_wstrb, m1_wstrb, s_wstrb;
  logic [DW-1:0] m0_rdata, m1_rdata, s_rdata;
  logic          s_valid, s_ready;
  logic          timeout_pulse, timeout_master, grant_id, busy;

  proc_bus_arbiter #(
    .ADDR_W  (AW),
    .DATA_W  (DW),
    .TIMEOUT (TO)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .m0_valid       (m0_valid),
    .m0_ready       (m0_ready),
    .m0_addr        (m0_addr),
    .m0_wdata       (m0_wdata),
    .m0_wstrb       (m0_wstrb),
    .m0_rdata       (m0_rdata),
    .m1_valid       (m1_valid),
    .m1_ready       (m1_ready),
    .m1_addr        (m1_addr),
    .m1_wdata       (m1_wdata),
    .m1_wstrb       (m1_wstrb),
    .m1_rdata       (m1_rdata),
    .s_valid        (s_valid),
    .s_ready        (s_ready),
    .s_addr         (s_addr),
    .s_wdata        (s_wdata),
    .s_wstrb        (s_wstrb),
    .s_rdata        (s_rdata),
    .timeout_pulse  (timeout_pulse),
    .timeout_master (timeout_master),
    .grant_id       (grant_id),
    .busy           (busy)
  );

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [SW-1:0] wstrb;
    logic [DW-1:0] rdata;
    bit            tmo;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int   exp_grant_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   slave_lat = 0;
  int   grant_cyc = 0;
  int   ready_cyc[2];
  bit   exp_pulse = 0;
  logic exp_tmaster = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] rom(input logic [AW-1:0] a);
    case (a)
      5'h04:   return 32'h0000_0003;
      5'h09:   return 32'h0000_1234;
      default: return {16'hC0DE, 11'h0, a};
    endcase
  endfunction

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Slave model: answers after slave_lat stalled cycles of a grant, reads come from a fixed table.
  initial begin
    int scnt;
    scnt    = 0;
    s_ready = 1'b0;
    s_rdata = '0;
    forever begin
      @(negedge clk);
      if (reset || !busy) begin
        scnt    = 0;
        s_ready = 1'b0;
        s_rdata = '0;
      end else begin
        s_ready = (scnt == slave_lat);
        s_rdata = (s_wstrb == '0) ? rom(s_addr) : '0;
        scnt++;
      end
    end
  end

  task automatic retire(input int m);
    exp_t e;
    if ((m == 0 && q0.size() == 0) || (m == 1 && q1.size() == 0)) begin
      check($sformatf("unexpected_ready_m%0d", m), 1, 0);
      return;
    end
    e = (m == 0) ? q0.pop_front() : q1.pop_front();
    ready_cyc[m] = cyc;
    check($sformatf("rdata_m%0d", m), (m == 0) ? m0_rdata : m1_rdata, e.rdata);
    check($sformatf("other_rdata_m%0d", m), (m == 0) ? m1_rdata : m0_rdata, 0);
    if (e.tmo) begin
      check("s_valid_at_timeout", s_valid, 0);
      exp_pulse   = 1;
      exp_tmaster = (m == 1);
    end else begin
      check("s_valid_at_done", s_valid, 1);
      check("s_addr", s_addr, e.addr);
      check("s_wdata", s_wdata, e.wdata);
      check("s_wstrb", s_wstrb, e.wstrb);
    end
  endtask

  // Monitor: samples just after the falling edge, where all inputs are settled.
  initial begin
    bit busy_prev;
    busy_prev = 0;
    forever begin
      @(negedge clk);
      #1;
      if (reset) begin
        busy_prev = 0;
        exp_pulse = 0;
        continue;
      end
      check("timeout_pulse", timeout_pulse, exp_pulse);
      if (exp_pulse) check("timeout_master", timeout_master, exp_tmaster);
      exp_pulse = 0;
      if (busy && !busy_prev) begin
        grant_cyc = cyc;
        if (exp_grant_q.size() == 0) check("unexpected_grant", 1, 0);
        else check("grant_id", grant_id, exp_grant_q.pop_front());
      end
      busy_prev = busy;
      if (m0_ready) retire(0);
      if (m1_ready) retire(1);
    end
  end

  // Raise a request (caller is just after a rising edge) and hold it until its completion edge.
  task automatic issue(input int m, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                       input logic [SW-1:0] wstrb);
    exp_t e;
    bit   got;
    e.addr  = addr;
    e.wdata = wdata;
    e.wstrb = wstrb;
    e.tmo   = (slave_lat >= TO);
    e.rdata = e.tmo ? DEFAULT_ERR_RDATA : ((wstrb != '0) ? '0 : rom(addr));
    if (m == 0) begin
      q0.push_back(e);
      m0_addr = addr; m0_wdata = wdata; m0_wstrb = wstrb; m0_valid = 1'b1;
    end else begin
      q1.push_back(e);
      m1_addr = addr; m1_wdata = wdata; m1_wstrb = wstrb; m1_valid = 1'b1;
    end
    got = 0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      #1;
      got = (m == 0) ? m0_ready : m1_ready;
    end
    if (!got) check($sformatf("ready_wait_m%0d", m), 0, 1);
    @(posedge clk);
    #1;
    if (m == 0) m0_valid = 1'b0;
    else        m1_valid = 1'b0;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL global_time_limit");
    $fatal(1, "bench time limit");
  end

  initial begin
    reset    = 1'b0;
    m0_valid = 1'b1; m0_addr = '0; m0_wdata = '0; m0_wstrb = '0;
    m1_valid = 1'b1; m1_addr = '0; m1_wdata = '0; m1_wstrb = '0;
    #1 reset = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    check("rst_s_valid", s_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_m0_ready", m0_ready, 0);
    check("rst_m1_ready", m1_ready, 0);
    check("rst_grant_id", grant_id, 0);
    check("rst_timeout_pulse", timeout_pulse, 0);
    check("rst_timeout_master", timeout_master, 0);
    m0_valid = 1'b0;
    m1_valid = 1'b0;
    @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk);
    #1;

    // Single read, two stall cycles.
    slave_lat = 2;
    exp_grant_q.push_back(0);
    fork
      issue(0, 5'h04, '0, '0);
      begin
        @(negedge clk); #1; check("arb_cycle_s_valid", s_valid, 0);
        @(negedge clk); #1; check("grant_cycle_s_valid", s_valid, 1);
      end
    join
    check("read_latency", ready_cyc[0] - grant_cyc, 2);
    check("idle_after_read", busy, 0);

    // Priority now belongs to master 1.
    slave_lat = 0;
    exp_grant_q.push_back(1);
    exp_grant_q.push_back(0);
    fork
      issue(0, 5'h01, '0, '0);
      issue(1, 5'h07, '0, '0);
    join

    // After reset priority is back at master 0; master 1 writes.
    apply_reset();
    exp_grant_q.push_back(0);
    exp_grant_q.push_back(1);
    fork
      issue(0, 5'h02, '0, '0);
      issue(1, 5'h10, 32'h0000_00A5, 4'hF);
    join
    check("second_grant_gap", grant_cyc - ready_cyc[0], 2);

    // Continuous requests alternate grants.
    for (int i = 0; i < 3; i++) begin
      exp_grant_q.push_back(0);
      exp_grant_q.push_back(1);
    end
    fork
      for (int i = 0; i < 3; i++) issue(0, AW'(i + 8), '0, '0);
      for (int j = 0; j < 3; j++) issue(1, AW'(j + 16), 32'h100 + j, 4'h3);
    join

    // m0 completes (prio -> 1), then m1 times out (prio must flip back to 0).
    exp_grant_q.push_back(0);
    issue(0, 5'h05, '0, '0);
    slave_lat = 1000;
    exp_grant_q.push_back(1);
    issue(1, 5'h03, '0, '0);
    check("timeout_latency", ready_cyc[1] - grant_cyc, TO - 1);
    slave_lat = 0;
    exp_grant_q.push_back(0);
    exp_grant_q.push_back(1);
    fork
      issue(0, 5'h06, '0, '0);
      issue(1, 5'h0A, 32'h5A5A_0001, 4'h1);
    join

    // Slave answers in the very cycle the watchdog would expire.
    slave_lat = TO - 1;
    exp_grant_q.push_back(0);
    issue(0, 5'h09, '0, '0);
    check("race_latency", ready_cyc[0] - grant_cyc, TO - 1);

    // Asynchronous reset in the middle of a granted transaction.
    slave_lat = 1000;
    exp_grant_q.push_back(0);
    m0_addr = 5'h01; m0_wdata = '0; m0_wstrb = '0; m0_valid = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #1;
    check("pre_reset_s_valid", s_valid, 1);
    #1 reset = 1'b1;
    #1;
    check("async_rst_s_valid", s_valid, 0);
    check("async_rst_busy", busy, 0);
    check("async_rst_m0_ready", m0_ready, 0);
    check("async_rst_timeout_master", timeout_master, 0);
    m0_valid = 1'b0;
    q0.delete();
    @(posedge clk);
    #1 reset = 1'b0;
    slave_lat = 0;
    exp_grant_q.push_back(0);
    exp_grant_q.push_back(1);
    fork
      issue(0, 5'h04, '0, '0);
      issue(1, 5'h0B, '0, '0);
    join

    repeat (3) @(posedge clk);
    #1;
    check("q0_drained", q0.size(), 0);
    check("q1_drained", q1.size(), 0);
    check("grants_drained", exp_grant_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/proc_bus_arbiter.md
Name: proc_bus_arbiter

Overview:
- Two-master, one-slave arbiter for the data processor's memory-mapped register port, which uses the native valid/ready bus.
- Master 0 is the CPU bus, gated by the processor address select. Master 1 is a secondary configuration master, such as a kernel/mode loader.
- Grants are round-robin and locked for one whole transaction.
- A watchdog terminates stalled transactions with an error response, so neither master can hang the bus.

Parameters:
- ADDR_W, 5: slave register offset width.
- DATA_W, 32: data width. wstrb width is DATA_W/8.
- TIMEOUT, 64: maximum cycles a granted transaction may wait for s_ready. Legal range 2..65535.
- ERR_RDATA, 32'hDEAD_BEEF: rdata returned on a timeout.

Ports:
- clk  in  1  single clock
- reset  in  1  asynchronous, active-high reset
- m0_valid  in  1  master 0 request
- m0_ready  out  1  master 0 completion
- m0_addr  in  ADDR_W  master 0 offset
- m0_wdata  in  DATA_W  master 0 write data
- m0_wstrb  in  DATA_W/8  master 0 byte strobes; 0 means read
- m0_rdata  out  DATA_W  master 0 read data
- m1_valid, m1_ready, m1_addr, m1_wdata, m1_wstrb, m1_rdata: same as the m0 signals, for master 1
- s_valid  out  1  slave request
- s_ready  in  1  slave completion
- s_addr  out  ADDR_W  slave offset
- s_wdata  out  DATA_W  slave write data
- s_wstrb  out  DATA_W/8  slave strobes
- s_rdata  in  DATA_W  slave read data
- timeout_pulse  out  1  one-cycle pulse when a transaction times out
- timeout_master  out  1  master id of the most recent timeout
- grant_id  out  1  currently granted master; valid when busy=1
- busy  out  1  high while a transaction is granted

Behaviour:
- States:
  - IDLE: no grant.
  - GRANT0: master 0 granted.
  - GRANT1: master 1 granted.
- Reset (asynchronous): state=IDLE, prio=0, wd_cnt=0, timeout_pulse=0, timeout_master=0. All s_* outputs and m*_ready are 0 and m*_rdata is 0 while in reset.
- IDLE transitions:
  - Only m0_valid: go to GRANT0.
  - Only m1_valid: go to GRANT1.
  - Both: go to GRANT(prio).
  - Neither: stay in IDLE.
  - Arbitration takes one registered cycle, so s_valid first rises the cycle after m*_valid is seen in IDLE.
- In GRANTn:
  - s_valid = mn_valid. s_addr, s_wdata and s_wstrb pass through combinationally from master n.
  - mn_ready = s_ready. mn_rdata = s_rdata.
  - The other master sees ready=0 and rdata=0.
- In IDLE: s_valid=0 and s_addr/s_wdata/s_wstrb=0.
- Completion: mn_ready=1 ends the transaction. In the next cycle, state=IDLE and prio = the other master (1-n). This gives one mandatory idle bubble between grants.
- Withdrawal: if mn_valid drops while in GRANTn without completion (a protocol violation), return to IDLE the next cycle. prio is unchanged and no ready is generated.
- Watchdog:
  - wd_cnt clears on entry to GRANTn and increments each GRANTn cycle in which s_ready=0.
  - When wd_cnt==TIMEOUT-1 and s_ready=0, that cycle is the timeout cycle.
  - In the timeout cycle: mn_ready=1, mn_rdata=ERR_RDATA, s_valid forced 0, timeout_pulse=1 (registered, asserted the following cycle), timeout_master=n.
  - The state then goes to IDLE and prio flips, as for a normal completion.
- If s_ready arrives in the same cycle the watchdog expires, the normal completion wins: s_rdata is returned and there is no timeout_pulse.
- s_ready sampled in IDLE is ignored.
- The other master's requests may arrive and be held at any time. They are never lost, only deferred.
- Fairness: under continuous requests from both masters, grants alternate 0,1,0,1,...
- Worst-case wait for a requesting master is one full transaction of the other master plus 2 cycles.
- busy=1 in GRANT0/GRANT1. grant_id=0 in GRANT0 and IDLE, 1 in GRANT1.
- wd_cnt width is clog2(TIMEOUT) and it saturates; it never wraps.
- A write is any nonzero wstrb. The arbiter does not interpret addresses or data.

Decomposition:
- Shared package proc_bus_pkg:
  - State encoding constants: ARB_IDLE=2'd0, ARB_GRANT0=2'd1, ARB_GRANT1=2'd2.
  - Default ERR_RDATA.
  - Master-id constants.
- Optional sub-module proc_bus_watchdog: the counter, expiry compare and timeout pulse register, with inputs clr, stall.
- The mux and FSM stay in the top.

Test Plan:
- Single read: m0_valid with addr=5'h04, wstrb=0; slave gives s_ready 2 cycles after s_valid with s_rdata=32'h0000_0003 -> s_valid rises 1 cycle after m0_valid; m0_ready=1 with m0_rdata=3; state back in IDLE next cycle; prio=1.
- Simultaneous requests: m0 and m1 both raise valid in the same cycle; m1 writes 32'h0000_00A5, wstrb=4'hF; prio=0 -> m0 serviced first. m1 is granted exactly 2 cycles after m0_ready, and s_wdata=32'hA5 appears on the bus.
- Alternation: both masters request continuously for 6 transactions with s_ready in the first cycle -> grant_id sequence 0,1,0,1,0,1; no transaction is lost.
- Timeout: TIMEOUT=8; m1 read with s_ready held 0 -> m1_ready=1 and m1_rdata=32'hDEAD_BEEF on the 8th grant cycle; timeout_pulse for 1 cycle; timeout_master=1; next grant goes to m0.
- Race at expiry: s_ready=1 in the same cycle the watchdog expires, with s_rdata=32'h1234 -> master receives 32'h1234; no timeout_pulse.
- Reset mid-transaction: assert reset during GRANT0 with s_valid=1 -> s_valid, m0_ready and busy drop immediately (asynchronously); after release state=IDLE, prio=0, and a fresh m0 request completes normally.
